// File: rtl/sad_sched_pkg.sv
// Shared definitions for the SAD search scheduler: default widths, FSM states,
// the "no SAD seen yet" sentinel and the width of a queued job record.
package sad_sched_pkg;

  localparam int A_WIDTH_DEF   = 15;
  localparam int CNT_WIDTH_DEF = 8;
  localparam int ID_WIDTH_DEF  = 4;

  localparam logic [31:0] SAD_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_REPORT = 3'd5
  } state_t;

  // Queued job record is packed as {id, count, stride, base}
  function automatic int job_width(input int aw, input int cw, input int iw);
    return 2 * aw + cw + iw;
  endfunction

endpackage

// File: rtl/sad_req_fifo.sv
// Small synchronous request queue. Read data is the head entry, visible
// combinationally; an entry pushed into an empty queue is poppable next cycle.
module sad_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == {CW{1'b0}});
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally for power-of-two depth
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sad_search_sched.sv
// Job scheduler for a shared 16x16 SAD engine: dequeues search jobs, launches
// the engine once per candidate, keeps the running minimum and reports it.
module sad_search_sched
  import sad_sched_pkg::*;
#(
  parameter int A_WIDTH    = A_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int TIMEOUT    = 1024,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Req_Valid,
  output logic                 Req_Ready,
  input  logic [A_WIDTH-1:0]   Req_Base,
  input  logic [A_WIDTH-1:0]   Req_Stride,
  input  logic [CNT_WIDTH-1:0] Req_Count,
  input  logic [ID_WIDTH-1:0]  Req_Id,
  output logic                 Eng_Go,
  output logic [A_WIDTH-1:0]   Eng_Base,
  input  logic                 Eng_Done,
  input  logic [31:0]          Eng_Sad,
  output logic                 Res_Valid,
  input  logic                 Res_Ready,
  output logic [31:0]          Res_MinSad,
  output logic [CNT_WIDTH-1:0] Res_MinIdx,
  output logic [ID_WIDTH-1:0]  Res_Id,
  output logic                 Res_Err,
  output logic                 Busy
);

  localparam int JW = job_width(A_WIDTH, CNT_WIDTH, ID_WIDTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t               state;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [JW-1:0]        fifo_din;
  logic [JW-1:0]        fifo_dout;

  logic [A_WIDTH-1:0]   job_base;
  logic [A_WIDTH-1:0]   job_stride;
  logic [CNT_WIDTH-1:0] job_count;
  logic [ID_WIDTH-1:0]  job_id;
  logic [CNT_WIDTH-1:0] cand_idx;
  logic [A_WIDTH-1:0]   cand_addr;
  logic [31:0]          min_sad;
  logic [CNT_WIDTH-1:0] min_idx;
  logic [31:0]          cur_sad;
  logic [TW-1:0]        timer;

  logic                 sad_better;
  logic [31:0]          upd_min_sad;
  logic [CNT_WIDTH-1:0] upd_min_idx;
  logic                 last_cand;
  logic [A_WIDTH-1:0]   next_addr;
  logic                 timer_expired;

  // Ready is forced low during reset so nothing is accepted into a queue being cleared
  assign Req_Ready = ~fifo_full & ~Rst;
  assign fifo_push = Req_Valid & Req_Ready;
  assign fifo_pop  = (state == ST_IDLE) & ~fifo_empty;
  assign fifo_din  = {Req_Id, Req_Count, Req_Stride, Req_Base};
  assign Busy      = (state != ST_IDLE);

  sad_req_fifo #(
    .WIDTH (JW),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // Strict compare keeps the earlier index on ties; address step wraps modulo 2^A_WIDTH
  always_comb begin
    sad_better    = (cur_sad < min_sad);
    upd_min_sad   = sad_better ? cur_sad : min_sad;
    upd_min_idx   = sad_better ? cand_idx : min_idx;
    last_cand     = (cand_idx == (job_count - CNT_WIDTH'(1)));
    next_addr     = cand_addr + job_stride;
    timer_expired = (timer == TW'(TIMEOUT - 1));
  end

  // Job sequencing FSM with registered engine and result outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= ST_IDLE;
      job_base    <= {A_WIDTH{1'b0}};
      job_stride  <= {A_WIDTH{1'b0}};
      job_count   <= {CNT_WIDTH{1'b0}};
      job_id      <= {ID_WIDTH{1'b0}};
      cand_idx    <= {CNT_WIDTH{1'b0}};
      cand_addr   <= {A_WIDTH{1'b0}};
      min_sad     <= 32'h0000_0000;
      min_idx     <= {CNT_WIDTH{1'b0}};
      cur_sad     <= 32'h0000_0000;
      timer       <= {TW{1'b0}};
      Eng_Go      <= 1'b0;
      Eng_Base    <= {A_WIDTH{1'b0}};
      Res_Valid   <= 1'b0;
      Res_MinSad  <= 32'h0000_0000;
      Res_MinIdx  <= {CNT_WIDTH{1'b0}};
      Res_Id      <= {ID_WIDTH{1'b0}};
      Res_Err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            {job_id, job_count, job_stride, job_base} <= fifo_dout;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cand_idx  <= {CNT_WIDTH{1'b0}};
          min_sad   <= SAD_MAX;
          min_idx   <= {CNT_WIDTH{1'b0}};
          cand_addr <= job_base;
          if (job_count == {CNT_WIDTH{1'b0}}) begin
            Res_Valid  <= 1'b1;
            Res_MinSad <= SAD_MAX;
            Res_MinIdx <= {CNT_WIDTH{1'b0}};
            Res_Id     <= job_id;
            Res_Err    <= 1'b0;
            state      <= ST_REPORT;
          end else begin
            Eng_Go   <= 1'b1;
            Eng_Base <= job_base;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          Eng_Go <= 1'b0;
          timer  <= {TW{1'b0}};
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (Eng_Done) begin
            cur_sad <= Eng_Sad;
            state   <= ST_UPDATE;
          end else if (timer_expired) begin
            Res_Valid  <= 1'b1;
            Res_MinSad <= min_sad;
            Res_MinIdx <= min_idx;
            Res_Id     <= job_id;
            Res_Err    <= 1'b1;
            state      <= ST_REPORT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_UPDATE: begin
          min_sad <= upd_min_sad;
          min_idx <= upd_min_idx;
          if (last_cand) begin
            Res_Valid  <= 1'b1;
            Res_MinSad <= upd_min_sad;
            Res_MinIdx <= upd_min_idx;
            Res_Id     <= job_id;
            Res_Err    <= 1'b0;
            state      <= ST_REPORT;
          end else begin
            cand_idx  <= cand_idx + CNT_WIDTH'(1);
            cand_addr <= next_addr;
            Eng_Base  <= next_addr;
            Eng_Go    <= 1'b1;
            state     <= ST_LAUNCH;
          end
        end
        ST_REPORT: begin
          if (Res_Ready) begin
            Res_Valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
